// File: rtl/debug_slave_scan_ctrl.sv
// debug_slave_scan_ctrl
// Scan controller between the virtual-JTAG adapter (strobes already in the
// clk domain) and the CPU debug core. It captures a per-instruction status
// word, shifts the data register, validates the scan length and delivers each
// accepted update as a one-hot action/no-action command.
//
// Optional build feature: define DEBUG_SLAVE_PARITY_EN to enable the odd
// parity check on bit DR_W-2 of the shifted word. Without it, err[2] stays 0.
//
// Handshake (action_valid/action_ready): action_valid rises after the edge that
// accepts an update and stays high, with jdo and take_* stable, until an edge
// where action_ready is high. If a new update is accepted on that same edge, valid
// stays high and the new word replaces the old one, giving back-to-back commands.
// action_valid never depends combinationally on action_ready.

module debug_slave_scan_ctrl #(
  parameter int IR_W = 2,
  parameter int DR_W = 38
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         vs_uir,
  input  logic                         vs_cdr,
  input  logic                         vs_sdr,
  input  logic                         vs_udr,
  input  logic [IR_W-1:0]              ir_in,
  input  logic                         tdi,
  output logic                         tdo,
  output logic [IR_W-1:0]              ir_out,
  input  logic [(2**IR_W)*DR_W-1:0]    capture_data,
  output logic [DR_W-1:0]              jdo,
  output logic [(2**IR_W)-1:0]         take_action,
  output logic [(2**IR_W)-1:0]         take_no_action,
  output logic                         action_valid,
  input  logic                         action_ready,
  output logic [2:0]                   err,
  input  logic                         err_clr,
  output logic                         fsm_state
);

  localparam int NUM_CMD = 2**IR_W;
  localparam int CW      = $clog2(DR_W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DR_W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DR_W + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [DR_W-1:0]   sr;
  logic [IR_W-1:0]   ir_q;
  logic [IR_W-1:0]   cmd_ir;
  logic [CW-1:0]     shift_cnt;

  logic [DR_W-1:0]   cap_word;
  logic              do_cdr;
  logic              do_sdr;
  logic              do_udr;
  logic              do_uir;
  logic              cnt_ok;
  logic              par_ok;
  logic              busy;
  logic              accept;
  logic [2:0]        err_set;

  // Only the highest-priority strobe acts: cdr > sdr > udr > uir.
  assign do_cdr = vs_cdr;
  assign do_sdr = vs_sdr & ~vs_cdr;
  assign do_udr = vs_udr & ~vs_sdr & ~vs_cdr;
  assign do_uir = vs_uir & ~vs_udr & ~vs_sdr & ~vs_cdr;

  assign cnt_ok = (shift_cnt == CNT_FULL);

`ifdef DEBUG_SLAVE_PARITY_EN
  // Bit DR_W-2 is odd parity over DR_W-3..0, so bits DR_W-2..0 XOR to 1.
  assign par_ok = ^sr[DR_W-2:0];
`else
  assign par_ok = 1'b1;
`endif

  // A pending command that the consumer is not taking this cycle blocks a new one.
  assign busy   = action_valid & ~action_ready;
  assign accept = do_udr & cnt_ok & par_ok & ~busy;

  // Classify the update-DR outcome into at most one sticky error source,
  // checked in order: length, then parity, then overrun.
  always_comb begin
    err_set    = 3'b000;
    err_set[1] = do_udr & ~cnt_ok;
`ifdef DEBUG_SLAVE_PARITY_EN
    err_set[2] = do_udr & cnt_ok & ~par_ok;
`endif
    err_set[0] = do_udr & cnt_ok & par_ok & busy;
  end

  // Select the capture slice addressed by the current instruction.
  always_comb begin
    cap_word = '0;
    for (int k = 0; k < NUM_CMD; k++) begin
      if (ir_q == IR_W'(k)) begin
        cap_word = capture_data[k*DR_W +: DR_W];
      end
    end
    // The MSB of the captured word reports whether any sticky error is set.
    cap_word[DR_W-1] = |err;
  end

  // Shift register, instruction, counter, command word and sticky errors.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr        <= '0;
      ir_q      <= '0;
      cmd_ir    <= '0;
      shift_cnt <= '0;
      jdo       <= '0;
      err       <= 3'b000;
    end else begin
      if (do_cdr) begin
        sr        <= cap_word;
        shift_cnt <= '0;
      end else if (do_sdr) begin
        sr <= {tdi, sr[DR_W-1:1]};
        if (shift_cnt != CNT_SAT) begin
          shift_cnt <= shift_cnt + 1'b1;
        end
      end else if (accept) begin
        jdo    <= sr;
        cmd_ir <= ir_q;
      end else if (do_uir) begin
        ir_q <= ir_in;
      end
      // Set-dominant: a bit being set this cycle survives a simultaneous clear.
      err <= (err & ~{3{err_clr}}) | err_set;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Handshake next state: an accepted update always leaves a command pending.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_PEND;
        end
      end
      S_PEND: begin
        if (accept) begin
          state_nx = S_PEND;
        end else if (action_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign action_valid = (state == S_PEND);
  assign fsm_state    = state;
  assign tdo          = sr[0];

  // Status readback: bit0 command pending, bit1 any sticky error.
  always_comb begin
    ir_out    = '0;
    ir_out[0] = action_valid;
    ir_out[1] = |err;
  end

  // One-hot command decode; the MSB of jdo chooses action versus no-action.
  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    for (int k = 0; k < NUM_CMD; k++) begin
      if (action_valid && (cmd_ir == IR_W'(k))) begin
        take_action[k]    = jdo[DR_W-1];
        take_no_action[k] = ~jdo[DR_W-1];
      end
    end
  end

endmodule

// File: tb/tb_debug_slave_scan_ctrl.sv
// Bench for debug_slave_scan_ctrl: directed scans plus randomized scans,
// checked against a transaction-level model with an expected-command queue.

module tb_debug_slave_scan_ctrl;

  localparam int IR_W    = 2;
  localparam int DR_W    = 38;
  localparam int NUM_CMD = 4;

  logic                      clk;
  logic                      reset_n;
  logic                      vs_uir, vs_cdr, vs_sdr, vs_udr;
  logic [IR_W-1:0]           ir_in;
  logic                      tdi;
  logic                      tdo;
  logic [IR_W-1:0]           ir_out;
  logic [NUM_CMD*DR_W-1:0]   capture_data;
  logic [DR_W-1:0]           jdo;
  logic [NUM_CMD-1:0]        take_action;
  logic [NUM_CMD-1:0]        take_no_action;
  logic                      action_valid;
  logic                      action_ready;
  logic [2:0]                err;
  logic                      err_clr;
  logic                      fsm_state;

  debug_slave_scan_ctrl #(.IR_W(IR_W), .DR_W(DR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .ir_in(ir_in), .tdi(tdi), .tdo(tdo), .ir_out(ir_out),
    .capture_data(capture_data), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .action_valid(action_valid), .action_ready(action_ready),
    .err(err), .err_clr(err_clr), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [IR_W+DR_W-1:0] exp_q[$];   // {ir, word} of each accepted command, in order
  bit                   tdi_bits[$]; // bits shifted since the last capture
  logic [DR_W-1:0]      capw;        // word loaded by the last capture
  logic [IR_W-1:0]      m_ir;
  bit                   m_pending;
  logic [2:0]           m_err;
  int                   ready_mode;  // 0: ready low, 1: ready high, 2: random
  int                   n_checks;
  int                   n_errs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the scan rules to one clock edge, using the inputs of that cycle.
  task automatic model_step(input bit cdr, input bit sdr, input bit udr, input bit uir,
                            input logic [IR_W-1:0] iv, input bit ti, input bit clr,
                            input bit rdy);
    bit              acc;
    logic [2:0]      set;
    logic [DR_W-1:0] w;
    acc = 0;
    set = 3'b000;
    if (cdr) begin
      capw = capture_data[int'(m_ir)*DR_W +: DR_W];
      capw[DR_W-1] = |m_err;
      tdi_bits.delete();
    end else if (sdr) begin
      tdi_bits.push_back(ti);
    end else if (udr) begin
      if (tdi_bits.size() != DR_W) begin
        set[1] = 1'b1;
      end else begin
        for (int i = 0; i < DR_W; i++) w[i] = tdi_bits[i];
`ifdef DEBUG_SLAVE_PARITY_EN
        if ((^w[DR_W-2:0]) == 1'b0) set[2] = 1'b1;
        else
`endif
        if (m_pending && !rdy) set[0] = 1'b1;
        else begin
          acc = 1;
          exp_q.push_back({m_ir, w});
        end
      end
    end else if (uir) begin
      m_ir = iv;
    end
    if (acc) m_pending = 1;
    else if (m_pending && rdy) m_pending = 0;
    m_err = (m_err & ~{3{clr}}) | set;
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit cdr, input bit sdr, input bit udr, input bit uir,
                      input logic [IR_W-1:0] iv, input bit ti, input bit clr);
    int k;
    vs_cdr = cdr; vs_sdr = sdr; vs_udr = udr; vs_uir = uir;
    ir_in = iv; tdi = ti; err_clr = clr;
    case (ready_mode)
      0:       action_ready = 1'b0;
      1:       action_ready = 1'b1;
      default: action_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    model_step(cdr, sdr, udr, uir, iv, ti, clr, action_ready);
    #1;
    vs_cdr = 0; vs_sdr = 0; vs_udr = 0; vs_uir = 0; err_clr = 0;
    if (cdr || sdr) begin
      k = tdi_bits.size();
      check("tdo", 64'(tdo), 64'((k < DR_W) ? capw[k] : tdi_bits[k-DR_W]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, '0, 0, 0);
  endtask

  // Full scan sequence: select instruction, capture, shift len bits, then update.
  // umode is the ready policy applied on the update cycle only.
  task automatic scan(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] w,
                      input int len, input int umode, input bit clr);
    int save;
    tick(0, 0, 0, 1, ir, 0, 0);
    tick(1, 0, 0, 0, '0, 0, 0);
    for (int i = 0; i < len; i++)
      tick(0, 1, 0, 0, '0, (i < DR_W) ? w[i] : 1'($urandom_range(0, 1)), 0);
    save = ready_mode;
    ready_mode = umode;
    tick(0, 0, 1, 0, '0, 0, clr);
    ready_mode = save;
    check("err", 64'(err), 64'(m_err));
    check("ir_out", 64'(ir_out), 64'({|m_err, m_pending}));
    check("valid", 64'(action_valid), 64'(m_pending));
  endtask

  task automatic do_reset(input int n);
    vs_cdr = 1; vs_sdr = 1; vs_udr = 1; vs_uir = 1;
    ir_in = '1; tdi = 1; err_clr = 0; action_ready = 0;
    reset_n = 0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_tdo", 64'(tdo), 0);
    check("rst_ir_out", 64'(ir_out), 0);
    check("rst_jdo", 64'(jdo), 0);
    check("rst_take", 64'(take_action), 0);
    check("rst_notake", 64'(take_no_action), 0);
    check("rst_valid", 64'(action_valid), 0);
    check("rst_err", 64'(err), 0);
    reset_n = 1;
    vs_cdr = 0; vs_sdr = 0; vs_udr = 0; vs_uir = 0; tdi = 0;
    exp_q.delete();
    tdi_bits.delete();
    capw = '0; m_ir = '0; m_pending = 0; m_err = 3'b000;
  endtask

  function automatic logic [DR_W-1:0] fix_par(input logic [DR_W-1:0] w);
    logic [DR_W-1:0] r;
    r = w;
`ifdef DEBUG_SLAVE_PARITY_EN
    r[DR_W-2] = ~^r[DR_W-3:0];
`endif
    return r;
  endfunction

  // ---------------- monitor ----------------
  // Every transfer (valid and ready high before an edge) retires the oldest expected command.
  always @(negedge clk) begin
    logic [IR_W+DR_W-1:0] e;
    logic [NUM_CMD-1:0]   oh;
    if (reset_n && action_valid) begin
      check("take_excl", 64'(take_action & take_no_action), 0);
      if (action_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_cmd: jdo %0h with no command expected at %0t", jdo, $time);
        end else begin
          e = exp_q.pop_front();
          oh = '0;
          oh[e[IR_W+DR_W-1:DR_W]] = 1'b1;
          check("sb_jdo", 64'(jdo), 64'(e[DR_W-1:0]));
          check("sb_take", 64'(take_action), 64'(e[DR_W-1] ? oh : '0));
          check("sb_notake", 64'(take_no_action), 64'(e[DR_W-1] ? '0 : oh));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [DR_W-1:0] W_ACT  = 38'h20_0000_00AB; // MSB set, parity consistent
  localparam logic [DR_W-1:0] W_NOAC = 38'h00_0000_00AB; // MSB clear, parity consistent
  localparam logic [DR_W-1:0] W_B    = 38'h31_2345_6789;
  localparam logic [DR_W-1:0] W_C    = 38'h05_5555_AAAA;

  initial begin
    logic [DR_W-1:0] w;
    int              len;
    n_checks = 0; n_errs = 0; ready_mode = 0;
    reset_n = 0; action_ready = 0; err_clr = 0;
    vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0; ir_in = '0; tdi = 0;
    for (int i = 0; i < NUM_CMD*DR_W; i++) capture_data[i] = 1'($urandom_range(0, 1));
    #2;
    do_reset(3);

    // Action command on instruction 2.
    ready_mode = 0;
    scan(2'd2, W_ACT, DR_W, 0, 0);
    check("act_take", 64'(take_action), 64'(4'b0100));
    check("act_notake", 64'(take_no_action), 0);
    check("act_jdo", 64'(jdo), 64'(W_ACT));
    ready_mode = 1;
    idle(1);
    check("act_clear", 64'(action_valid), 0);

    // No-action command on instruction 1.
    ready_mode = 0;
    scan(2'd1, W_NOAC, DR_W, 0, 0);
    check("noact_notake", 64'(take_no_action), 64'(4'b0010));
    check("noact_take", 64'(take_action), 0);
    ready_mode = 1;
    idle(1);

    // Short scans (one short, one long), then clear.
    scan(2'd3, W_B, DR_W-1, 1, 0);
    check("short_err", 64'(err), 64'(3'b010));
    check("short_irout1", 64'(ir_out[1]), 1);
    tick(0, 0, 0, 0, '0, 0, 1);
    check("short_clr", 64'(err), 0);
    scan(2'd3, W_B, DR_W+3, 1, 0);
    check("long_err", 64'(err), 64'(3'b010));
    tick(0, 0, 0, 0, '0, 0, 1);

    // Overrun then back-to-back.
    ready_mode = 0;
    scan(2'd0, W_ACT, DR_W, 0, 0);
    scan(2'd3, W_B, DR_W, 0, 0);
    check("ovr_err", 64'(err), 64'(3'b001));
    check("ovr_jdo", 64'(jdo), 64'(W_ACT));
    tick(0, 0, 0, 0, '0, 0, 1);
    scan(2'd1, fix_par(W_C), DR_W, 1, 0);
    check("b2b_err", 64'(err), 0);
    check("b2b_jdo", 64'(jdo), 64'(fix_par(W_C)));
    ready_mode = 1;
    idle(1);

    // Strobe priority: cdr beats sdr; udr beats uir.
    tick(1, 1, 0, 0, '0, 1, 0);
    tick(0, 0, 1, 1, 2'd3, 0, 0);
    check("prio_err", 64'(err), 64'(m_err));

`ifdef DEBUG_SLAVE_PARITY_EN
    tick(0, 0, 0, 0, '0, 0, 1);
    w = fix_par(W_B);
    w[DR_W-2] = ~w[DR_W-2];
    scan(2'd2, w, DR_W, 1, 0);
    check("par_err", 64'(err), 64'(3'b100));
    tick(0, 0, 0, 0, '0, 0, 1);
    scan(2'd2, fix_par(W_B), DR_W, 0, 0);
    check("par_ok_valid", 64'(action_valid), 1);
    idle(1);
`endif

    // Randomized scans with random ready and occasional clears.
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      w = {$urandom, $urandom};
      w = fix_par(w);
      case ($urandom_range(0, 7))
        0:       len = DR_W - 1;
        1:       len = DR_W + 1;
        default: len = DR_W;
      endcase
      scan(2'($urandom_range(0, 3)), w, len, 2, 1'($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 2));
    end

    // Reset mid-handshake discards the pending command.
    ready_mode = 1;
    idle(2);
    ready_mode = 0;
    scan(2'd2, fix_par(W_C), DR_W, 0, 0);
    do_reset(2);
    check("rst_mid_valid", 64'(action_valid), 0);

    // Drain: every expected command must have been observed.
    ready_mode = 1;
    idle(3);
    check("drain", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
